// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment decoder: digit patterns, blank pattern
// and FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
  localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
  localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
  localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
  localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
  localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
  localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
  localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
  localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
  localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;
  localparam logic [6:0] SEG_DIGIT_A = 7'h77;
  localparam logic [6:0] SEG_DIGIT_B = 7'h7C;
  localparam logic [6:0] SEG_DIGIT_C = 7'h39;
  localparam logic [6:0] SEG_DIGIT_D = 7'h5E;
  localparam logic [6:0] SEG_DIGIT_E = 7'h79;
  localparam logic [6:0] SEG_DIGIT_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational seven-segment pattern to hex nibble lookup.
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_DIGIT_0: nibble = 4'h0;
      SEG_DIGIT_1: nibble = 4'h1;
      SEG_DIGIT_2: nibble = 4'h2;
      SEG_DIGIT_3: nibble = 4'h3;
      SEG_DIGIT_4: nibble = 4'h4;
      SEG_DIGIT_5: nibble = 4'h5;
      SEG_DIGIT_6: nibble = 4'h6;
      SEG_DIGIT_7: nibble = 4'h7;
      SEG_DIGIT_8: nibble = 4'h8;
      SEG_DIGIT_9: nibble = 4'h9;
      SEG_DIGIT_A: nibble = 4'hA;
      SEG_DIGIT_B: nibble = 4'hB;
      SEG_DIGIT_C: nibble = 4'hC;
      SEG_DIGIT_D: nibble = 4'hD;
      SEG_DIGIT_E: nibble = 4'hE;
      SEG_DIGIT_F: nibble = 4'hF;
      default:     hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_decode.sv
// Seven-segment bus decoder: waits for a pattern to stay stable for
// STABLE_CYCLES cycles, then reports it as a hex digit, blank or error.
//
//   state     | meaning
//   ST_IDLE   | post-reset, bus unchanged since reset
//   ST_SETTLE | bus changed, counting consecutive unchanged cycles
//   ST_HOLD   | current pattern reported, waiting for next change
module seg_decode
  import seg_pkg::*;
#(
  parameter logic [15:0] STABLE_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic       hex_valid,
  output logic       err,
  output logic       blank,
  output logic [7:0] valid_cnt
);

  // Report fires on the edge where the count would reach STABLE_CYCLES-1.
  localparam logic [15:0] CNT_LAST = STABLE_CYCLES - 16'd2;

  seg_state_t  state;
  logic [7:0]  seg_q;
  logic [7:0]  seg_prev;
  logic [15:0] stable_cnt;
  logic        changed;
  logic        lut_hit;
  logic [3:0]  lut_nibble;

  assign changed = (seg_q != seg_prev);

  seg_pattern_lut u_lut (
    .pattern (seg_q[6:0]),
    .hit     (lut_hit),
    .nibble  (lut_nibble)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      seg_q      <= 8'h00;
      seg_prev   <= 8'h00;
      stable_cnt <= 16'd0;
      hex_out    <= 4'h0;
      dp_out     <= 1'b0;
      hex_valid  <= 1'b0;
      err        <= 1'b0;
      blank      <= 1'b1;
      valid_cnt  <= 8'h00;
    end else begin
      seg_q     <= seg_in;
      seg_prev  <= seg_q;
      hex_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (changed) begin
            state      <= ST_SETTLE;
            stable_cnt <= 16'd0;
          end
        end
        ST_SETTLE: begin
          if (changed) begin
            stable_cnt <= 16'd0;
          end else if (stable_cnt == CNT_LAST) begin
            state      <= ST_HOLD;
            stable_cnt <= stable_cnt + 16'd1;
            if (seg_q[6:0] == SEG_BLANK) begin
              blank  <= 1'b1;
              dp_out <= seg_q[7];
            end else if (lut_hit) begin
              hex_out   <= lut_nibble;
              dp_out    <= seg_q[7];
              blank     <= 1'b0;
              hex_valid <= 1'b1;
              valid_cnt <= valid_cnt + 8'd1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            stable_cnt <= stable_cnt + 16'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          stable_cnt <= 16'd0;
        end
      endcase
    end
  end

endmodule
